// File: rtl/shield_mon_pkg.sv
// Shared record layout and constants for the shield monitor.
// The event record captures the environment input, proposed and corrected actions.
package shield_mon_pkg;

    localparam int EVT_W        = 7;
    localparam int EVT_U1       = 6;
    localparam int EVT_PROP_LSB = 3;
    localparam int EVT_CORR_LSB = 0;

    // Field order matches the offsets above: [6] u1, [5:3] proposed, [2:0] corrected.
    typedef struct packed {
        logic       u1;
        logic [2:0] prop;
        logic [2:0] corr;
    } shield_evt_t;

endpackage

// File: rtl/shield_monitor_if.sv
// Valid/ready channel carrying override records from the monitor to the host.
interface shield_monitor_if;
    import shield_mon_pkg::*;

    logic        evt_valid;
    logic        evt_ready;
    shield_evt_t evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/shield_evt_fifo.sv
// Synchronous event FIFO with async reset and synchronous flush.
// Head data comes straight from storage, so there is no path from pop to outputs.
module shield_evt_fifo
    import shield_mon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic        pop,
    input  shield_evt_t push_data,
    output logic        full,
    output logic        empty,
    output shield_evt_t head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    shield_evt_t     mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [AW:0]     count_reg, count_next;
    logic            do_push, do_pop;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + (AW + 1)'(1);
                2'b01:   count_next = count_reg - (AW + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/shield_monitor.sv
// Passive observer of the safety shield: counts steps and overrides, queues
// override records, and flags intervention streaks and dropped records.
module shield_monitor
    import shield_mon_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STREAK_LIMIT = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             u1,
    input  logic             l1,
    input  logic             l2,
    input  logic             l3,
    input  logic             l1__1,
    input  logic             l2__1,
    input  logic             l3__1,
    shield_monitor_if.master evt,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] ovr_count,
    output logic             streak_alarm,
    output logic             overflow
);

    localparam int STREAK_W = $clog2(STREAK_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STREAK_LIMIT);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    logic [2:0]          prop, corr, diff;
    logic                override, sample, push, pop_req, pop_fire;
    logic                fifo_full, fifo_empty;
    shield_evt_t         rec;
    logic [CNT_W-1:0]    step_reg, step_next;
    logic [CNT_W-1:0]    ovr_reg, ovr_next;
    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic                overflow_reg, overflow_next;

    assign prop = {l3, l2, l1};
    assign corr = {l3__1, l2__1, l1__1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_diff
            assign diff[gi] = prop[gi] ^ corr[gi];
        end
    endgenerate

    assign override = |diff;
    assign sample   = enable && !clear;
    assign push     = sample && override;
    assign pop_req  = evt.evt_ready && !clear;
    assign pop_fire = pop_req && evt.evt_valid;
    assign rec      = '{u1: u1, prop: prop, corr: corr};

    shield_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (clear),
        .push     (push),
        .pop      (pop_req),
        .push_data(rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_data(evt.evt_data)
    );

    assign evt.evt_valid = !fifo_empty;

    always_comb begin
        step_next     = step_reg;
        ovr_next      = ovr_reg;
        streak_next   = streak_reg;
        overflow_next = overflow_reg;
        if (clear) begin
            step_next     = '0;
            ovr_next      = '0;
            streak_next   = '0;
            overflow_next = 1'b0;
        end else if (enable) begin
            if (step_reg != CNT_MAX) step_next = step_reg + CNT_W'(1);
            if (override) begin
                if (ovr_reg != CNT_MAX)       ovr_next    = ovr_reg + CNT_W'(1);
                if (streak_reg != STREAK_MAX) streak_next = streak_reg + STREAK_W'(1);
                // Record is lost only when no slot frees up this cycle.
                if (fifo_full && !pop_fire)   overflow_next = 1'b1;
            end else begin
                streak_next = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_reg     <= '0;
            ovr_reg      <= '0;
            streak_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            step_reg     <= step_next;
            ovr_reg      <= ovr_next;
            streak_reg   <= streak_next;
            overflow_reg <= overflow_next;
        end
    end

    assign step_count   = step_reg;
    assign ovr_count    = ovr_reg;
    assign streak_alarm = (streak_reg == STREAK_MAX);
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_shield_monitor.sv
// Directed bench for shield_monitor: a queue-based reference model checked every
// cycle, two instances (16-bit and 4-bit counters), plus literal spot checks.
module tb_shield_monitor;
    import shield_mon_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0, clear = 1'b0, u1 = 1'b0;
    logic l1 = 1'b0, l2 = 1'b0, l3 = 1'b0;
    logic l1__1 = 1'b0, l2__1 = 1'b0, l3__1 = 1'b0;
    logic ready = 1'b0;

    logic [15:0] step_a, ovr_a;
    logic [3:0]  step_b, ovr_b;
    logic        alarm_a, alarm_b, ovf_a, ovf_b;

    shield_monitor_if ifa ();
    shield_monitor_if ifb ();
    assign ifa.evt_ready = ready;
    assign ifb.evt_ready = ready;

    shield_monitor #(.CNT_W(16), .FIFO_DEPTH(DEPTH), .STREAK_LIMIT(LIMIT)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .u1(u1),
        .l1(l1), .l2(l2), .l3(l3), .l1__1(l1__1), .l2__1(l2__1), .l3__1(l3__1),
        .evt(ifa.master), .step_count(step_a), .ovr_count(ovr_a),
        .streak_alarm(alarm_a), .overflow(ovf_a)
    );

    shield_monitor #(.CNT_W(4), .FIFO_DEPTH(DEPTH), .STREAK_LIMIT(LIMIT)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear), .u1(u1),
        .l1(l1), .l2(l2), .l3(l3), .l1__1(l1__1), .l2__1(l2__1), .l3__1(l3__1),
        .evt(ifb.master), .step_count(step_b), .ovr_count(ovr_b),
        .streak_alarm(alarm_b), .overflow(ovf_b)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a queue of 7-bit records.
    int          m_step16 = 0, m_ovr16 = 0, m_step4 = 0, m_ovr4 = 0, m_streak = 0;
    bit          m_ovf = 1'b0;
    logic [6:0]  m_q[$];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_step16 = 0; m_ovr16 = 0; m_step4 = 0; m_ovr4 = 0; m_streak = 0;
            m_ovf = 1'b0;
            m_q.delete();
        end else if (clear) begin
            m_step16 = 0; m_ovr16 = 0; m_step4 = 0; m_ovr4 = 0; m_streak = 0;
            m_ovf = 1'b0;
            m_q.delete();
        end else begin
            bit popped;
            popped = ready && (m_q.size() > 0);
            if (popped) void'(m_q.pop_front());
            if (enable) begin
                m_step16 = (m_step16 < 65535) ? m_step16 + 1 : 65535;
                m_step4  = (m_step4 < 15) ? m_step4 + 1 : 15;
                if ({l3, l2, l1} != {l3__1, l2__1, l1__1}) begin
                    m_ovr16  = (m_ovr16 < 65535) ? m_ovr16 + 1 : 65535;
                    m_ovr4   = (m_ovr4 < 15) ? m_ovr4 + 1 : 15;
                    m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
                    if (m_q.size() < DEPTH) m_q.push_back({u1, l3, l2, l1, l3__1, l2__1, l1__1});
                    else m_ovf = 1'b1;
                end else begin
                    m_streak = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [6:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 7'd0;
        chk("a_valid", 32'(ifa.evt_valid), 32'(m_q.size() > 0));
        chk("b_valid", 32'(ifb.evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("a_data", 32'(ifa.evt_data), 32'(head));
            chk("b_data", 32'(ifb.evt_data), 32'(head));
        end
        chk("a_step", 32'(step_a), 32'(m_step16));
        chk("a_ovr", 32'(ovr_a), 32'(m_ovr16));
        chk("b_step", 32'(step_b), 32'(m_step4));
        chk("b_ovr", 32'(ovr_b), 32'(m_ovr4));
        chk("a_alarm", 32'(alarm_a), 32'(m_streak == LIMIT));
        chk("b_alarm", 32'(alarm_b), 32'(m_streak == LIMIT));
        chk("a_ovf", 32'(ovf_a), 32'(m_ovf));
        chk("b_ovf", 32'(ovf_b), 32'(m_ovf));
    end

    // Drive one cycle of inputs, return just after the following falling edge.
    task automatic cyc(input logic en, input logic clr, input logic uu,
                       input logic [2:0] p, input logic [2:0] c, input logic rdy);
        enable = en; clear = clr; u1 = uu;
        {l3, l2, l1} = p;
        {l3__1, l2__1, l1__1} = c;
        ready = rdy;
        @(negedge clock); #1;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        chk("rst_step", 32'(step_a), 32'd0);
        chk("rst_valid", 32'(ifa.evt_valid), 32'd0);
        reset_n = 1'b1;
        cyc(0, 0, 0, 3'b000, 3'b000, 0);

        // 5 matching cycles
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 3'b001, 3'b001, 0);
        chk("lit_step5", 32'(step_a), 32'd5);
        chk("lit_ovr0", 32'(ovr_a), 32'd0);
        chk("lit_valid0", 32'(ifa.evt_valid), 32'd0);
        chk("lit_alarm0", 32'(alarm_a), 32'd0);

        // single override
        cyc(1, 0, 1, 3'b100, 3'b000, 0);
        chk("lit_valid1", 32'(ifa.evt_valid), 32'd1);
        chk("lit_data1", 32'(ifa.evt_data), 32'b1100000);
        chk("lit_ovr1", 32'(ovr_a), 32'd1);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_drained", 32'(ifa.evt_valid), 32'd0);

        // streak of three then a match
        cyc(1, 0, 0, 3'b011, 3'b011, 1);
        cyc(1, 0, 0, 3'b010, 3'b011, 1);
        cyc(1, 0, 0, 3'b010, 3'b011, 1);
        chk("lit_alarm_2nd", 32'(alarm_a), 32'd0);
        cyc(1, 0, 0, 3'b010, 3'b011, 1);
        chk("lit_alarm_3rd", 32'(alarm_a), 32'd1);
        cyc(1, 0, 0, 3'b111, 3'b111, 1);
        chk("lit_alarm_fall", 32'(alarm_a), 32'd0);

        // overflow: 6 overrides, host stalled
        cyc(0, 1, 0, 3'b000, 3'b000, 0);
        for (int i = 1; i <= 6; i++) cyc(1, 0, 1'(i % 2), 3'(i), 3'b000, 0);
        chk("lit_ovr6", 32'(ovr_a), 32'd6);
        chk("lit_ovf1", 32'(ovf_a), 32'd1);
        chk("lit_head1", 32'(ifa.evt_data), 32'b1001000);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_head2", 32'(ifa.evt_data), 32'b0010000);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_head3", 32'(ifa.evt_data), 32'b1011000);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_head4", 32'(ifa.evt_data), 32'b0100000);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_empty4", 32'(ifa.evt_valid), 32'd0);

        // push into full FIFO with simultaneous pop
        cyc(0, 1, 0, 3'b000, 3'b000, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 3'b101, 3'b001, 0);
        cyc(1, 0, 1, 3'b110, 3'b001, 1);
        chk("lit_ovf_full_pop", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_last_head", 32'(ifa.evt_data), 32'b1110001);
        cyc(0, 0, 0, 3'b000, 3'b000, 1);
        chk("lit_occ4", 32'(ifa.evt_valid), 32'd0);

        // saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 3'b001, 3'b000, 1);
        chk("lit_b_step15", 32'(step_b), 32'd15);
        chk("lit_b_ovr15", 32'(ovr_b), 32'd15);
        chk("lit_a_step25", 32'(step_a), 32'd25);
        cyc(1, 1, 1, 3'b001, 3'b000, 1);
        chk("lit_clr_step", 32'(step_b), 32'd0);
        chk("lit_clr_ovr", 32'(ovr_a), 32'd0);
        chk("lit_clr_valid", 32'(ifa.evt_valid), 32'd0);

        // asynchronous reset mid-operation
        cyc(1, 0, 0, 3'b010, 3'b000, 0);
        cyc(1, 0, 0, 3'b010, 3'b000, 0);
        reset_n = 1'b0;
        #1;
        chk("lit_async_step", 32'(step_a), 32'd0);
        chk("lit_async_valid", 32'(ifa.evt_valid), 32'd0);
        @(negedge clock); #1;
        reset_n = 1'b1;
        cyc(1, 0, 0, 3'b001, 3'b001, 0);
        cyc(0, 0, 0, 3'b000, 3'b000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
